icache_refill_controller: RTL and testbench

//  Sequences line refills for the 2-way instruction cache (19b tag / 7b index / 6b offset, 64B lines).

---
 rtl/icache_pkg.sv | 38 +++
 rtl/icache_lru_table.sv | 37 +++
 rtl/icache_refill_controller.sv | 168 ++++++++++++++++
 tb/tb_icache_refill_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, types and helpers for the instruction-cache refill path.
package icache_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int WORD_WIDTH     = 32;
  localparam int TAG_WIDTH      = 19;
  localparam int INDEX_WIDTH    = 7;
  localparam int OFFSET_WIDTH   = 6;
  localparam int WAYS           = 2;
  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_BITS      = 512;
  localparam int BEAT_WIDTH     = 4;
  localparam int SETS           = 1 << INDEX_WIDTH;

  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [LINE_BITS-1:0]   line_t;
  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [BEAT_WIDTH-1:0]  beat_t;

  localparam beat_t LAST_BEAT = beat_t'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FILL
  } refill_state_t;

  // Lowest invalid way is always preferred; with a full set the LRU bit decides.
  function automatic logic pick_victim(input logic [WAYS-1:0] valid_ways,
                                       input logic            lru_way);
    if (!valid_ways[0]) return 1'b0;
    if (!valid_ways[1]) return 1'b1;
    return lru_way;
  endfunction

endpackage

// File: rtl/icache_lru_table.sv
// Per-set 1-bit LRU state for the 2-way instruction cache.
// Each entry holds the least-recently-used way of its set. Hit and fill
// updates may land in the same cycle; the fill update wins on the same set.
module icache_lru_table
  import icache_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  index_t i_rd_index,
  output logic   o_rd_lru,
  input  logic   i_hit_we,
  input  index_t i_hit_index,
  input  logic   i_hit_lru,
  input  logic   i_fill_we,
  input  index_t i_fill_index,
  input  logic   i_fill_lru
);

  logic [SETS-1:0] r_lru;

  assign o_rd_lru = r_lru[i_rd_index];

  // LRU update: fill write is ordered last so it overrides a same-set hit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lru <= '0;
    end else begin
      if (i_hit_we) begin
        r_lru[i_hit_index] <= i_hit_lru;
      end
      if (i_fill_we) begin
        r_lru[i_fill_index] <= i_fill_lru;
      end
    end
  end

endmodule

// File: rtl/icache_refill_controller.sv
// Line refill sequencer for the 2-way instruction cache.
// Accepts a miss, chooses a victim way, reads 16 words one at a time over a
// single-outstanding memory port, assembles the 64-byte line and issues a
// one-cycle fill strobe. A bus error aborts the refill with a FillError pulse.
// Build option ICACHE_CRITICAL_WORD_FIRST_EN: start the beat sequence at the
// missing word (wrapping) and forward that first word early.
module icache_refill_controller
  import icache_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_miss_valid,
  output logic                  o_miss_ready,
  input  logic [ADDR_WIDTH-1:0] i_miss_address,
  input  logic [WAYS-1:0]       i_miss_valid_ways,
  input  logic                  i_hit_valid,
  input  index_t                i_hit_index,
  input  logic                  i_hit_way,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_address,
  input  logic                  i_mem_resp_valid,
  input  logic [WORD_WIDTH-1:0] i_mem_resp_data,
  input  logic                  i_mem_resp_error,
  output logic                  o_fill_valid,
  output index_t                o_fill_index,
  output logic                  o_fill_way,
  output tag_t                  o_fill_tag,
  output line_t                 o_fill_line,
  output logic                  o_forward_valid,
  output logic [WORD_WIDTH-1:0] o_forward_data,
  output logic                  o_fill_error,
  output logic                  o_busy
);

  refill_state_t r_state;
  refill_state_t w_next_state;

  tag_t   r_tag;
  index_t r_index;
  logic   r_way;
  beat_t  r_beat;   // word address of the current beat, wraps mod 16
  beat_t  r_count;  // completed beats, terminates the refill
  line_t  r_line;

  logic   w_accept;
  logic   w_good_resp;
  logic   w_lru_way;
  logic   w_victim;
  tag_t   w_miss_tag;
  index_t w_miss_index;
  beat_t  w_start_beat;
  logic   w_unused_addr;

  assign w_miss_tag   = i_miss_address[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_miss_index = i_miss_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_victim     = pick_victim(i_miss_valid_ways, w_lru_way);
  assign w_accept     = (r_state == IDLE) && i_miss_valid;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_start_beat    = i_miss_address[2 +: BEAT_WIDTH];
  assign w_unused_addr   = ^i_miss_address[1:0];
  assign o_forward_valid = w_good_resp && (r_count == '0);
  assign o_forward_data  = o_forward_valid ? i_mem_resp_data : '0;
`else
  assign w_start_beat    = '0;
  assign w_unused_addr   = ^i_miss_address[OFFSET_WIDTH-1:0];
  assign o_forward_valid = 1'b0;
  assign o_forward_data  = '0;
`endif

  assign o_mem_req_address = {r_tag, r_index, r_beat, 2'b00};
  assign o_fill_index      = r_index;
  assign o_fill_way        = r_way;
  assign o_fill_tag        = r_tag;
  assign o_fill_line       = r_line;
  assign o_busy            = (r_state != IDLE);

  icache_lru_table u_lru (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rd_index   (w_miss_index),
    .o_rd_lru     (w_lru_way),
    .i_hit_we     (i_hit_valid),
    .i_hit_index  (i_hit_index),
    .i_hit_lru    (~i_hit_way),
    .i_fill_we    (o_fill_valid),
    .i_fill_index (r_index),
    .i_fill_lru   (~r_way)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/strobe decode
  always_comb begin
    w_next_state    = r_state;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_fill_valid    = 1'b0;
    o_fill_error    = 1'b0;
    w_good_resp     = 1'b0;
    case (r_state)
      IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (i_mem_resp_valid) begin
          if (i_mem_resp_error) begin
            o_fill_error = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_good_resp  = 1'b1;
            w_next_state = (r_count == LAST_BEAT) ? FILL : REQ;
          end
        end
      end
      FILL: begin
        o_fill_valid = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Miss capture, beat/count tracking and line assembly
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag   <= '0;
      r_index <= '0;
      r_way   <= 1'b0;
      r_beat  <= '0;
      r_count <= '0;
      r_line  <= '0;
    end else begin
      if (w_accept) begin
        r_tag   <= w_miss_tag;
        r_index <= w_miss_index;
        r_way   <= w_victim;
        r_beat  <= w_start_beat;
        r_count <= '0;
      end
      if (w_good_resp) begin
        r_line[{r_beat, 5'b00000} +: WORD_WIDTH] <= i_mem_resp_data;
        r_beat  <= r_beat + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Randomized self-checking bench for icache_refill_controller.
// Reference model: LRU array, victim rule, expected beat addresses and the
// expected line derived from a hashed memory image.
module tb_icache_refill_controller;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_miss_valid;
  logic         o_miss_ready;
  logic [31:0]  i_miss_address;
  logic [1:0]   i_miss_valid_ways;
  logic         i_hit_valid;
  logic [6:0]   i_hit_index;
  logic         i_hit_way;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [31:0]  o_mem_req_address;
  logic         i_mem_resp_valid;
  logic [31:0]  i_mem_resp_data;
  logic         i_mem_resp_error;
  logic         o_fill_valid;
  logic [6:0]   o_fill_index;
  logic         o_fill_way;
  logic [18:0]  o_fill_tag;
  logic [511:0] o_fill_line;
  logic         o_forward_valid;
  logic [31:0]  o_forward_data;
  logic         o_fill_error;
  logic         o_busy;

  icache_refill_controller dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_miss_valid      (i_miss_valid),
    .o_miss_ready      (o_miss_ready),
    .i_miss_address    (i_miss_address),
    .i_miss_valid_ways (i_miss_valid_ways),
    .i_hit_valid       (i_hit_valid),
    .i_hit_index       (i_hit_index),
    .i_hit_way         (i_hit_way),
    .o_mem_req_valid   (o_mem_req_valid),
    .i_mem_req_ready   (i_mem_req_ready),
    .o_mem_req_address (o_mem_req_address),
    .i_mem_resp_valid  (i_mem_resp_valid),
    .i_mem_resp_data   (i_mem_resp_data),
    .i_mem_resp_error  (i_mem_resp_error),
    .o_fill_valid      (o_fill_valid),
    .o_fill_index      (o_fill_index),
    .o_fill_way        (o_fill_way),
    .o_fill_tag        (o_fill_tag),
    .o_fill_line       (o_fill_line),
    .o_forward_valid   (o_forward_valid),
    .o_forward_data    (o_forward_data),
    .o_fill_error      (o_fill_error),
    .o_busy            (o_busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit [127:0]  m_lru;
  logic [31:0] salt;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic hit(input logic [6:0] idx, input logic way);
    i_hit_valid = 1'b1;
    i_hit_index = idx;
    i_hit_way   = way;
    m_lru[idx]  = ~way;
    @(negedge clk);
    i_hit_valid = 1'b0;
  endtask

  // One complete miss; called at a negedge with the DUT idle.
  // stall/dly < 0 pick random values; err_beat/rst_beat < 0 disable the event.
  task automatic refill(input logic [31:0] a, input logic [1:0] vw, input int stall,
                        input int dly, input int err_beat, input int rst_beat,
                        input bit hold, input bit fill_hit);
    logic         exp_way;
    logic [511:0] exp_line;
    logic [31:0]  ba;
    logic [3:0]   bt;
    logic [6:0]   ix;
    logic [6:0]   hi;
    logic         hw;
    int           c0;
    int           st;
    int           dl;
    bit           fwd;
    ix = a[12:6];
    exp_way = !vw[0] ? 1'b0 : (!vw[1] ? 1'b1 : m_lru[ix]);
    for (int j = 0; j < 16; j++) exp_line[32*j +: 32] = memw({a[31:6], 4'(j), 2'b00});

    check("miss_ready_idle", o_miss_ready, 1'b1);
    i_miss_valid      = 1'b1;
    i_miss_address    = a;
    i_miss_valid_ways = vw;
    c0 = cyc;
    @(negedge clk);
    if (!hold) i_miss_valid = 1'b0;
    check("busy_after_accept", o_busy, 1'b1);

    for (int k = 0; k < 16; k++) begin
      bt = CWF ? (a[5:2] + 4'(k)) : 4'(k);
      ba = {a[31:6], bt, 2'b00};
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < st; s++) begin
        check("stall_addr", o_mem_req_address, ba);
        check("stall_miss_ready", o_miss_ready, 1'b0);
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'($urandom_range(0, 1));
        i_mem_resp_data  = 32'hDEAD_BEEF;
        if ($urandom_range(0, 3) == 0) begin
          hi = 7'($urandom);
          hw = 1'($urandom);
          i_hit_valid = 1'b1;
          i_hit_index = hi;
          i_hit_way   = hw;
          m_lru[hi]   = ~hw;
        end
        @(negedge clk);
        i_hit_valid      = 1'b0;
        i_mem_resp_valid = 1'b0;
      end
      check("req_valid", o_mem_req_valid, 1'b1);
      check("req_addr", o_mem_req_address, ba);
      i_mem_req_ready = 1'b1;
      @(negedge clk);
      i_mem_req_ready = 1'b0;
      dl = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
      for (int d = 0; d < dl; d++) begin
        check("req_low_in_resp", o_mem_req_valid, 1'b0);
        @(negedge clk);
      end
      if (k == rst_beat) begin
        i_miss_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_req_valid", o_mem_req_valid, 1'b0);
        check("rst_req_addr", o_mem_req_address, 32'h0);
        check("rst_fill_line", o_fill_line, 512'h0);
        check("rst_fill_valid", o_fill_valid, 1'b0);
        check("rst_fill_error", o_fill_error, 1'b0);
        m_lru = '0;
        @(negedge clk);
        i_rst = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data  = memw(ba);
        @(negedge clk);
        i_mem_resp_valid = 1'b0;
        for (int q = 0; q < 3; q++) begin
          check("stale_no_fill", o_fill_valid, 1'b0);
          check("stale_idle", o_busy, 1'b0);
          @(negedge clk);
        end
        return;
      end
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = memw(ba);
      i_mem_resp_error = (k == err_beat);
      fwd = CWF && (k == 0) && (k != err_beat);
      #1;
      check("fill_error_pulse", o_fill_error, k == err_beat);
      check("fwd_valid", o_forward_valid, fwd);
      check("fwd_data", o_forward_data, fwd ? memw(ba) : 32'h0);
      @(negedge clk);
      i_mem_resp_valid = 1'b0;
      i_mem_resp_error = 1'b0;
      if (k == err_beat) begin
        i_miss_valid = 1'b0;
        check("err_miss_ready", o_miss_ready, 1'b1);
        check("err_no_fill", o_fill_valid, 1'b0);
        check("err_fill_error_gone", o_fill_error, 1'b0);
        return;
      end
    end

    i_miss_valid = 1'b0;
    check("fill_valid", o_fill_valid, 1'b1);
    check("fill_index", o_fill_index, ix);
    check("fill_way", o_fill_way, exp_way);
    check("fill_tag", o_fill_tag, a[31:13]);
    check("fill_line", o_fill_line, exp_line);
    check("fill_no_error", o_fill_error, 1'b0);
    if (stall == 0 && dly == 0) check("latency", cyc - c0, 33);
    if (fill_hit) begin
      i_hit_valid = 1'b1;
      i_hit_index = ix;
      i_hit_way   = ~exp_way;
    end
    m_lru[ix] = ~exp_way;
    @(negedge clk);
    i_hit_valid = 1'b0;
    check("fill_one_cycle", o_fill_valid, 1'b0);
    check("idle_after_fill", o_miss_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] ra;
    int          re;
    i_rst             = 1'b1;
    i_miss_valid      = 1'b0;
    i_miss_address    = '0;
    i_miss_valid_ways = '0;
    i_hit_valid       = 1'b0;
    i_hit_index       = '0;
    i_hit_way         = 1'b0;
    i_mem_req_ready   = 1'b0;
    i_mem_resp_valid  = 1'b0;
    i_mem_resp_data   = '0;
    i_mem_resp_error  = 1'b0;
    salt              = $urandom;
    m_lru             = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", o_busy, 1'b0);
    check("reset_req_valid", o_mem_req_valid, 1'b0);
    check("reset_req_addr", o_mem_req_address, 32'h0);
    check("reset_fill_line", o_fill_line, 512'h0);
    check("reset_fill_valid", o_fill_valid, 1'b0);
    check("reset_fwd", o_forward_valid, 1'b0);
    i_rst = 1'b0;
    @(negedge clk);

    refill(32'h0000_2044, 2'b00, 0, 0, -1, -1, 1'b0, 1'b0);
    refill(32'h0000_4044, 2'b11, -1, -1, -1, -1, 1'b0, 1'b0);
    hit(7'd1, 1'b1);
    refill(32'h0000_6044, 2'b11, -1, -1, -1, -1, 1'b0, 1'b0);
    refill(32'h0001_8080, 2'b10, -1, -1, 5, -1, 1'b0, 1'b0);
    refill(32'h0002_A0C0, 2'b11, -1, -1, -1, 9, 1'b0, 1'b0);
    refill(32'h0000_0034, 2'b01, 0, 0, -1, -1, 1'b0, 1'b1);
    refill(32'h0001_2348, 2'b11, 4, 0, -1, -1, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      re = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      if ($urandom_range(0, 2) == 0) hit(7'($urandom), 1'($urandom));
      refill(ra, 2'($urandom), -1, -1, re, -1, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
